// File: rtl/pea_pkg.sv
// Shared definitions for the polynomial evaluation accelerator controllers.
//   - STP status codes reported on the status port
//   - FSM state type for the STP controller
//   - clog2 helper usable in parameter expressions
package pea_pkg;

    localparam logic [31:0] STP_OK         = 32'd0;
    localparam logic [31:0] STP_ERR_N      = 32'd2;
    localparam logic [31:0] STP_ERR_A      = 32'd3;
    localparam logic [31:0] STP_ERR_AVAIL  = 32'd4;
    localparam logic [31:0] STP_STATUS_RST = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_END    = 3'd4
    } stp_state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stp_rd_pipe.sv
// Read-tracking shift register for the STP controller.
// Each stage carries the valid bit and the coefficient index k of one
// outstanding data-RAM read; the last stage lines up with the cycle in
// which the RAM returns that read's data.
//   clk, rst   : clock, synchronous active-high clear of all stages
//   in_valid   : a read is issued this cycle
//   in_idx     : index k of that read
//   out_valid  : read data for out_idx is on the RAM bus this cycle
//   out_idx    : index k of the returning read
module stp_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [IDX_W-1:0] idx_q [DEPTH];
    logic [IDX_W-1:0] idx_d [DEPTH];

    always_comb begin
        vld_d[0] = in_valid;
        idx_d[0] = in_idx;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/stp_fsm_gen.sv
// STP (store-polynomial) controller: copies N+1 coefficients from data RAM,
// starting at rd_addr_data, into coefficient slot A of S RAM.
//   clk, rst               : clock, synchronous active-high reset
//   start_stp              : start request, sampled only in IDLE
//   rd_addr_data, A, N     : first data address, target slot, degree
//   avail_data             : unread words available in data RAM
//   next_c                 : data RAM read data (RD_LATENCY after enable)
//   busy, done_stp         : transfer in progress / one-cycle completion
//   en_rd_data, rd_addr_data_updated : data RAM read port
//   en_wr_S, wr_addr_S, c  : S RAM write port
//   result, status         : words written and status code, valid on done
// All outputs are registered.
module stp_fsm_gen
    import pea_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int BUFFER_SIZE = 1024,
    parameter int NUM_VEC     = 8,
    parameter int MAX_N       = 10,
    parameter int RD_LATENCY  = 1,
    parameter int A_W         = 4,
    parameter int N_W         = 5,
    parameter int ADDR_W      = clog2(BUFFER_SIZE),
    parameter int S_ADDR_W    = clog2(NUM_VEC * (MAX_N + 1))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_stp,
    input  logic [ADDR_W-1:0]    rd_addr_data,
    input  logic [A_W-1:0]       A,
    input  logic [N_W-1:0]       N,
    input  logic [ADDR_W:0]      avail_data,
    input  logic [WORD_SIZE-1:0] next_c,
    output logic                 busy,
    output logic                 done_stp,
    output logic                 en_rd_data,
    output logic [ADDR_W-1:0]    rd_addr_data_updated,
    output logic                 en_wr_S,
    output logic [S_ADDR_W-1:0]  wr_addr_S,
    output logic [WORD_SIZE-1:0] c,
    output logic [31:0]          result,
    output logic [31:0]          status
);

    localparam int STRIDE = MAX_N + 1;

    stp_state_e state_q, state_d;

    logic [A_W-1:0]       a_q, a_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [ADDR_W:0]      avail_q, avail_d;
    logic [N_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic                 wr_last_q, wr_last_d;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 en_rd_q, en_rd_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                 en_wr_q, en_wr_d;
    logic [S_ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [WORD_SIZE-1:0] c_q, c_d;
    logic [31:0]          result_q, result_d;
    logic [31:0]          status_q, status_d;

    logic                 pipe_vld;
    logic [N_W-1:0]       pipe_idx;

    // en_rd_q is high exactly in the cycles a read is on the bus, and
    // rd_cnt_q is that read's index, so they feed the tracker directly.
    stp_rd_pipe #(
        .DEPTH (RD_LATENCY),
        .IDX_W (N_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (en_rd_q),
        .in_idx    (rd_cnt_q),
        .out_valid (pipe_vld),
        .out_idx   (pipe_idx)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        n_d       = n_q;
        avail_d   = avail_q;
        rd_cnt_d  = rd_cnt_q;
        wr_last_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        en_rd_d   = en_rd_q;
        rd_addr_d = rd_addr_q;
        en_wr_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        c_d       = c_q;
        result_d  = result_q;
        status_d  = status_q;

        // Write path runs off the tracker independently of the state so
        // that returning reads are written even after STREAM has ended.
        if (pipe_vld) begin
            en_wr_d   = 1'b1;
            c_d       = next_c;
            wr_addr_d = S_ADDR_W'(a_q) * S_ADDR_W'(STRIDE) + S_ADDR_W'(pipe_idx);
            wr_last_d = (pipe_idx == n_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_stp) begin
                    a_d       = A;
                    n_d       = N;
                    avail_d   = avail_data;
                    rd_addr_d = rd_addr_data;
                    busy_d    = 1'b1;
                    state_d   = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (32'(n_q) > 32'(MAX_N)) begin
                    status_d = STP_ERR_N;
                    result_d = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_END;
                end else if (32'(a_q) >= 32'(NUM_VEC)) begin
                    status_d = STP_ERR_A;
                    result_d = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_END;
                end else if ((32'(n_q) + 32'd1) > 32'(avail_q)) begin
                    status_d = STP_ERR_AVAIL;
                    result_d = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_END;
                end else begin
                    en_rd_d  = 1'b1;
                    rd_cnt_d = '0;
                    state_d  = ST_STREAM;
                end
            end

            ST_STREAM: begin
                rd_addr_d = (rd_addr_q == ADDR_W'(BUFFER_SIZE - 1)) ? '0
                                                                    : rd_addr_q + 1'b1;
                rd_cnt_d  = rd_cnt_q + 1'b1;
                if (rd_cnt_q == n_q) begin
                    en_rd_d = 1'b0;
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // wr_last_q marks the cycle the final write is on the S RAM port.
                if (wr_last_q) begin
                    result_d = 32'(n_q) + 32'd1;
                    status_d = STP_OK;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_END;
                end
            end

            ST_END: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            n_q       <= '0;
            avail_q   <= '0;
            rd_cnt_q  <= '0;
            wr_last_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en_rd_q   <= 1'b0;
            rd_addr_q <= '0;
            en_wr_q   <= 1'b0;
            wr_addr_q <= '0;
            c_q       <= '0;
            result_q  <= '0;
            status_q  <= STP_STATUS_RST;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            n_q       <= n_d;
            avail_q   <= avail_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_last_q <= wr_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            en_rd_q   <= en_rd_d;
            rd_addr_q <= rd_addr_d;
            en_wr_q   <= en_wr_d;
            wr_addr_q <= wr_addr_d;
            c_q       <= c_d;
            result_q  <= result_d;
            status_q  <= status_d;
        end
    end

    assign busy                 = busy_q;
    assign done_stp             = done_q;
    assign en_rd_data           = en_rd_q;
    assign rd_addr_data_updated = rd_addr_q;
    assign en_wr_S              = en_wr_q;
    assign wr_addr_S            = wr_addr_q;
    assign c                    = c_q;
    assign result               = result_q;
    assign status               = status_q;

endmodule

// File: tb/tb_stp_fsm_gen.sv
`timescale 1ns/1ps
module tb_stp_fsm_gen;

    localparam int LOG = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stp = 1'b0;
    logic [9:0]  rd_addr_data = '0;
    logic [3:0]  a_in = '0;
    logic [4:0]  n_in = '0;
    logic [10:0] avail_in = '0;

    logic [15:0] next_c_w   [2];
    logic        busy_w     [2];
    logic        done_w     [2];
    logic        en_rd_w    [2];
    logic        en_wr_w    [2];
    logic [9:0]  rd_upd_w   [2];
    logic [6:0]  wr_addr_w  [2];
    logic [15:0] c_w        [2];
    logic [31:0] result_w   [2];
    logic [31:0] status_w   [2];

    logic [15:0] mem [1024];
    logic [15:0] rsp1;
    logic [15:0] rsp3 [3];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    // Monitor logs (written only by the monitor process)
    int          rd_n [2];
    int          wr_n [2];
    int          done_n [2];
    int          busy_hi [2];
    int          rd_cyc [2][LOG];
    int          rd_adr [2][LOG];
    int          wr_cyc [2][LOG];
    int          wr_adr [2][LOG];
    logic [15:0] wr_dat [2][LOG];
    int          done_cyc [2][LOG];
    logic        done_busy [2][LOG];
    logic [31:0] done_res [2][LOG];
    logic [31:0] done_sts [2][LOG];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stp_fsm_gen #(.RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .start_stp(start_stp), .rd_addr_data(rd_addr_data),
        .A(a_in), .N(n_in), .avail_data(avail_in), .next_c(next_c_w[0]),
        .busy(busy_w[0]), .done_stp(done_w[0]), .en_rd_data(en_rd_w[0]),
        .rd_addr_data_updated(rd_upd_w[0]), .en_wr_S(en_wr_w[0]),
        .wr_addr_S(wr_addr_w[0]), .c(c_w[0]), .result(result_w[0]), .status(status_w[0])
    );

    stp_fsm_gen #(.RD_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .start_stp(start_stp), .rd_addr_data(rd_addr_data),
        .A(a_in), .N(n_in), .avail_data(avail_in), .next_c(next_c_w[1]),
        .busy(busy_w[1]), .done_stp(done_w[1]), .en_rd_data(en_rd_w[1]),
        .rd_addr_data_updated(rd_upd_w[1]), .en_wr_S(en_wr_w[1]),
        .wr_addr_S(wr_addr_w[1]), .c(c_w[1]), .result(result_w[1]), .status(status_w[1])
    );

    // Data RAM models: read data valid LAT cycles after the enable cycle,
    // random garbage otherwise.
    always @(posedge clk) begin
        rsp1    <= en_rd_w[0] ? mem[rd_upd_w[0]] : 16'($urandom);
        rsp3[0] <= en_rd_w[1] ? mem[rd_upd_w[1]] : 16'($urandom);
        rsp3[1] <= rsp3[0];
        rsp3[2] <= rsp3[1];
    end
    assign next_c_w[0] = rsp1;
    assign next_c_w[1] = rsp3[2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en_rd_w[d] === 1'b1) begin
                if (rd_n[d] < LOG) begin
                    rd_cyc[d][rd_n[d]] = cyc;
                    rd_adr[d][rd_n[d]] = int'(rd_upd_w[d]);
                end
                rd_n[d]++;
            end
            if (en_wr_w[d] === 1'b1) begin
                if (wr_n[d] < LOG) begin
                    wr_cyc[d][wr_n[d]] = cyc;
                    wr_adr[d][wr_n[d]] = int'(wr_addr_w[d]);
                    wr_dat[d][wr_n[d]] = c_w[d];
                end
                wr_n[d]++;
            end
            if (done_w[d] === 1'b1) begin
                if (done_n[d] < LOG) begin
                    done_cyc[d][done_n[d]]  = cyc;
                    done_busy[d][done_n[d]] = busy_w[d];
                    done_res[d][done_n[d]]  = result_w[d];
                    done_sts[d][done_n[d]]  = status_w[d];
                end
                done_n[d]++;
            end
            if (busy_w[d] === 1'b1) busy_hi[d]++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic string tg(input int d, input string s);
        return $sformatf("L%0d.%s", lat_of(d), s);
    endfunction

    // Reference rules: first failing check in order N, A, availability.
    function automatic int exp_code(input int a, input int n, input int avail);
        if (n > 10) return 2;
        if (a >= 8) return 3;
        if (n + 1 > avail) return 4;
        return 0;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string pfx);
        for (int d = 0; d < 2; d++) begin
            check_eq(tg(d, {pfx, ".busy"}),    64'(busy_w[d]), 64'd0);
            check_eq(tg(d, {pfx, ".done"}),    64'(done_w[d]), 64'd0);
            check_eq(tg(d, {pfx, ".en_rd"}),   64'(en_rd_w[d]), 64'd0);
            check_eq(tg(d, {pfx, ".en_wr"}),   64'(en_wr_w[d]), 64'd0);
            check_eq(tg(d, {pfx, ".rd_addr"}), 64'(rd_upd_w[d]), 64'd0);
            check_eq(tg(d, {pfx, ".wr_addr"}), 64'(wr_addr_w[d]), 64'd0);
            check_eq(tg(d, {pfx, ".c"}),       64'(c_w[d]), 64'd0);
            check_eq(tg(d, {pfx, ".result"}),  64'(result_w[d]), 64'd0);
            check_eq(tg(d, {pfx, ".status"}),  64'(status_w[d]), 64'hFFFF_FFFF);
        end
    endtask

    task automatic run_xfer(input int a, input int n, input int base, input int avail, input bit poke);
        int t0, code, lat, done_exp, nexp, cnt, addr, wait_cnt;
        int rb[2], wb[2], db[2], bb[2];
        step();
        for (int d = 0; d < 2; d++) begin
            rb[d] = rd_n[d]; wb[d] = wr_n[d]; db[d] = done_n[d]; bb[d] = busy_hi[d];
        end
        t0 = cyc;
        start_stp    = 1'b1;
        a_in         = 4'(a);
        n_in         = 5'(n);
        rd_addr_data = 10'(base);
        avail_in     = 11'(avail);
        step();
        start_stp    = 1'b0;
        a_in         = 4'($urandom);
        n_in         = 5'($urandom);
        rd_addr_data = 10'($urandom);
        avail_in     = 11'($urandom);
        code = exp_code(a, n, avail);
        wait_cnt = 0;
        while (!(done_n[0] > db[0] && done_n[1] > db[1]) && wait_cnt < 80) begin
            if (poke && code == 0 && cyc <= t0 + 2 + n) start_stp = 1'($urandom);
            else start_stp = 1'b0;
            step();
            wait_cnt++;
        end
        start_stp = 1'b0;
        repeat (3) step();

        nexp = (code == 0) ? n + 1 : 0;
        for (int d = 0; d < 2; d++) begin
            lat = lat_of(d);
            done_exp = (code == 0) ? t0 + 4 + lat + n : t0 + 2;
            check_eq(tg(d, "done_cnt"),  64'(done_n[d] - db[d]), 64'd1);
            check_eq(tg(d, "done_cyc"),  64'(done_cyc[d][db[d]]), 64'(done_exp));
            check_eq(tg(d, "done_busy"), 64'(done_busy[d][db[d]]), 64'd0);
            check_eq(tg(d, "busy_cyc"),  64'(busy_hi[d] - bb[d]), 64'(done_exp - t0 - 1));
            check_eq(tg(d, "result"),    64'(done_res[d][db[d]]), 64'(nexp));
            check_eq(tg(d, "status"),    64'(done_sts[d][db[d]]), 64'(code));
            check_eq(tg(d, "rd_cnt"),    64'(rd_n[d] - rb[d]), 64'(nexp));
            check_eq(tg(d, "wr_cnt"),    64'(wr_n[d] - wb[d]), 64'(nexp));
            cnt = (rd_n[d] - rb[d] < nexp) ? rd_n[d] - rb[d] : nexp;
            for (int k = 0; k < cnt; k++) begin
                addr = (base + k) % 1024;
                check_eq(tg(d, $sformatf("rd%0d_cyc", k)), 64'(rd_cyc[d][rb[d] + k]), 64'(t0 + 2 + k));
                check_eq(tg(d, $sformatf("rd%0d_adr", k)), 64'(rd_adr[d][rb[d] + k]), 64'(addr));
            end
            cnt = (wr_n[d] - wb[d] < nexp) ? wr_n[d] - wb[d] : nexp;
            for (int k = 0; k < cnt; k++) begin
                addr = (base + k) % 1024;
                check_eq(tg(d, $sformatf("wr%0d_cyc", k)), 64'(wr_cyc[d][wb[d] + k]), 64'(t0 + 3 + lat + k));
                check_eq(tg(d, $sformatf("wr%0d_adr", k)), 64'(wr_adr[d][wb[d] + k]), 64'(a * 11 + k));
                check_eq(tg(d, $sformatf("wr%0d_dat", k)), 64'(wr_dat[d][wb[d] + k]), 64'(mem[addr]));
            end
            check_eq(tg(d, "rd_addr_upd"), 64'(rd_upd_w[d]),
                     64'((code == 0) ? (base + n + 1) % 1024 : base));
            check_eq(tg(d, "result_hold"), 64'(result_w[d]), 64'(nexp));
            check_eq(tg(d, "status_hold"), 64'(status_w[d]), 64'(code));
        end
    endtask

    task automatic reset_mid_stream();
        int wb[2], rb[2];
        step();
        start_stp    = 1'b1;
        a_in         = 4'd2;
        n_in         = 5'd5;
        rd_addr_data = 10'd300;
        avail_in     = 11'd600;
        step();                 // CHECK
        start_stp = 1'b0;
        step();                 // read 0
        step();                 // read 1
        for (int d = 0; d < 2; d++) check_eq(tg(d, "rst.rd1_active"), 64'(en_rd_w[d]), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("midrst");
        for (int d = 0; d < 2; d++) begin
            wb[d] = wr_n[d];
            rb[d] = rd_n[d];
        end
        repeat (10) step();
        for (int d = 0; d < 2; d++) begin
            check_eq(tg(d, "rst.no_wr"), 64'(wr_n[d] - wb[d]), 64'd0);
            check_eq(tg(d, "rst.no_rd"), 64'(rd_n[d] - rb[d]), 64'd0);
            check_eq(tg(d, "rst.idle"),  64'(busy_w[d]), 64'd0);
        end
    endtask

    task automatic held_start();
        int t0, lat, len, wait_cnt;
        int db[2], wb[2];
        step();
        for (int d = 0; d < 2; d++) begin
            db[d] = done_n[d];
            wb[d] = wr_n[d];
        end
        t0 = cyc;
        start_stp    = 1'b1;
        a_in         = 4'd3;
        n_in         = 5'd2;
        rd_addr_data = 10'd500;
        avail_in     = 11'd100;
        wait_cnt = 0;
        while (done_n[1] - db[1] < 3 && wait_cnt < 200) begin
            step();
            wait_cnt++;
        end
        start_stp = 1'b0;
        repeat (30) step();
        for (int d = 0; d < 2; d++) begin
            lat = lat_of(d);
            len = 4 + lat + 2;      // start edge to done for N=2
            check_eq(tg(d, "held.done_cnt_ge3"), 64'(done_n[d] - db[d] >= 3), 64'd1);
            for (int j = 0; j < 3; j++) begin
                check_eq(tg(d, $sformatf("held.done%0d_cyc", j)),
                         64'(done_cyc[d][db[d] + j]), 64'(t0 + (j + 1) * len + j));
                check_eq(tg(d, $sformatf("held.res%0d", j)), 64'(done_res[d][db[d] + j]), 64'd3);
                for (int k = 0; k < 3; k++) begin
                    check_eq(tg(d, $sformatf("held.x%0d.wr%0d_cyc", j, k)),
                             64'(wr_cyc[d][wb[d] + 3 * j + k]), 64'(t0 + j * (len + 1) + 3 + lat + k));
                    check_eq(tg(d, $sformatf("held.x%0d.wr%0d_adr", j, k)),
                             64'(wr_adr[d][wb[d] + 3 * j + k]), 64'(33 + k));
                    check_eq(tg(d, $sformatf("held.x%0d.wr%0d_dat", j, k)),
                             64'(wr_dat[d][wb[d] + 3 * j + k]), 64'(mem[500 + k]));
                end
            end
            check_eq(tg(d, "held.rd_addr_upd"), 64'(rd_upd_w[d]), 64'd503);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a, n, base, avail;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[100] = 16'd11;
        mem[101] = 16'd22;
        mem[102] = 16'd33;
        mem[103] = 16'd44;

        rst = 1'b1;
        repeat (3) step();
        check_reset("reset");
        rst = 1'b0;

        run_xfer(2, 3, 100, 500, 1'b0);     // nominal
        run_xfer(0, 11, 0, 1000, 1'b0);     // N too large
        run_xfer(8, 3, 0, 1000, 1'b0);      // A out of range
        run_xfer(1, 5, 0, 4, 1'b0);         // not enough data
        run_xfer(9, 11, 0, 1000, 1'b0);     // N error wins over A error
        run_xfer(1, 3, 1022, 50, 1'b0);     // address wrap
        run_xfer(7, 0, 40, 1, 1'b0);        // N=0, last slot, avail exactly 1
        run_xfer(0, 10, 200, 11, 1'b0);     // N=MAX_N fills slot 0
        run_xfer(4, 6, 10, 6, 1'b0);        // avail one short

        reset_mid_stream();
        run_xfer(2, 3, 100, 500, 1'b0);

        held_start();

        for (int i = 0; i < 40; i++) begin
            a     = $urandom_range(0, 9);
            n     = $urandom_range(0, 12);
            base  = $urandom_range(0, 1023);
            avail = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(11, 1024);
            run_xfer(a, n, base, avail, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
